// File: rtl/priority_irq_controller.sv
// priority_irq_controller
//   Registered N-channel interrupt controller. Request lines are captured into
//   a pending register. Each channel is either rising-edge or level triggered.
//   The highest-index pending channel that is not masked is presented on a
//   valid/ack handshake. A one-hot indicator of the presented channel is also
//   driven.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   irq_in     : request lines, synchronous to clk
//   irq_mask   : 1 = channel enabled, 0 = masked (blocks selection only)
//   irq_valid  : a request is being presented
//   irq_id     : index of the presented channel (valid with irq_valid)
//   irq_onehot : one-hot of irq_id while irq_valid, else 0
//   irq_ack    : service logic accepts the presented request
//   pending    : raw pending register
module priority_irq_controller #(
    parameter int               N_IRQ     = 8,
    parameter int               ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
    parameter logic [N_IRQ-1:0] EDGE_MODE = {N_IRQ{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] irq_onehot,
    input  logic             irq_ack,
    output logic [N_IRQ-1:0] pending
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [N_IRQ-1:0] set_vec, clr_vec, eligible;
    logic [ID_W-1:0]  top_id;
    logic             handshake;

    // Pending update. A new set wins over a same-cycle clear so that a
    // request arriving in the ack cycle is not lost.
    always_comb begin
        irq_prev_d = irq_in;
        set_vec    = (irq_in & ~irq_prev_q & EDGE_MODE) | (irq_in & ~EDGE_MODE);
        handshake  = (state_q == PRESENT) && irq_ack;
        clr_vec    = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr_vec[i] = handshake && (id_q == ID_W'(i));
        end
        pending_d = set_vec | (pending_q & ~clr_vec);
    end

    // Highest-index eligible channel; ascending scan so the last hit wins.
    always_comb begin
        eligible = pending_q & irq_mask;
        top_id   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (eligible[i]) top_id = ID_W'(i);
        end
    end

    // Selection only happens in IDLE, which gives the mandatory idle cycle
    // between presentations and means no preemption while PRESENT.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    id_d    = top_id;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            irq_prev_q <= '0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_prev_d;
            id_q       <= id_d;
        end
    end

    // Outputs come straight from flops, so an async reset drops them at once.
    always_comb begin
        irq_valid  = (state_q == PRESENT);
        irq_id     = id_q;
        pending    = pending_q;
        irq_onehot = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            irq_onehot[i] = irq_valid && (id_q == ID_W'(i));
        end
    end

endmodule

// File: tb/tb_priority_irq_controller.sv
module tb_priority_irq_controller;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_in, irq_mask, irq_onehot, pending;
    logic         irq_valid, irq_ack;
    logic [2:0]   irq_id;

    // channel 5 level-triggered, all others rising-edge
    priority_irq_controller #(
        .N_IRQ(N), .ID_W(3), .EDGE_MODE(8'hDF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_mask(irq_mask),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_onehot(irq_onehot),
        .irq_ack(irq_ack), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] in;
        logic [N-1:0] mask;
        logic         ack;
        logic         v;
        logic [2:0]   id;
        logic [N-1:0] pend;
    } vec_t;

    typedef struct {
        int           idx;
        logic         v;
        logic [2:0]   id;
        logic [N-1:0] oh;
        logic [N-1:0] pend;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic addv(input logic [N-1:0] in, input logic [N-1:0] mask, input logic ack,
                        input logic v, input logic [2:0] id, input logic [N-1:0] pend);
        vec_t r;
        r.in = in; r.mask = mask; r.ack = ack; r.v = v; r.id = id; r.pend = pend;
        vq.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [N-1:0] one;

        // inputs applied before an edge, outputs expected after that edge
        //   in     mask   ack v  id pend
        // single pulse on bit 2
        addv(8'h04, 8'hFF, 0, 0, 0, 8'h04);
        addv(8'h00, 8'hFF, 0, 1, 2, 8'h04);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h00);
        // priority 2,1,0
        addv(8'h07, 8'hFF, 0, 0, 0, 8'h07);
        addv(8'h00, 8'hFF, 0, 1, 2, 8'h07);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h03);
        addv(8'h00, 8'hFF, 0, 1, 1, 8'h03);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h01);
        addv(8'h00, 8'hFF, 0, 1, 0, 8'h01);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h00);
        // masking; ack in IDLE is ignored
        addv(8'h81, 8'h7F, 1, 0, 0, 8'h81);
        addv(8'h00, 8'h7F, 0, 1, 0, 8'h81);
        addv(8'h00, 8'h7F, 1, 0, 0, 8'h80);
        addv(8'h00, 8'hFF, 0, 1, 7, 8'h80);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h00);
        // no preemption, no withdrawal on mask change
        addv(8'h02, 8'hFF, 0, 0, 0, 8'h02);
        addv(8'h00, 8'hFF, 0, 1, 1, 8'h02);
        addv(8'h40, 8'hFF, 0, 1, 1, 8'h42);
        addv(8'h00, 8'h00, 0, 1, 1, 8'h42);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h40);
        addv(8'h00, 8'hFF, 0, 1, 6, 8'h40);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h00);
        // set/clear collision on edge channel 3
        addv(8'h08, 8'hFF, 0, 0, 0, 8'h08);
        addv(8'h00, 8'hFF, 0, 1, 3, 8'h08);
        addv(8'h08, 8'hFF, 1, 0, 0, 8'h08);
        addv(8'h00, 8'hFF, 0, 1, 3, 8'h08);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h00);
        // level channel 5 held high
        addv(8'h20, 8'hFF, 0, 0, 0, 8'h20);
        addv(8'h20, 8'hFF, 0, 1, 5, 8'h20);
        addv(8'h20, 8'hFF, 1, 0, 0, 8'h20);
        addv(8'h20, 8'hFF, 0, 1, 5, 8'h20);
        addv(8'h20, 8'hFF, 1, 0, 0, 8'h20);
        addv(8'h00, 8'hFF, 0, 1, 5, 8'h20);
        addv(8'h00, 8'hFF, 1, 0, 0, 8'h00);
        addv(8'h00, 8'hFF, 0, 0, 0, 8'h00);

        // reset held with all requests high
        rst_n = 1'b0; irq_in = 8'hFF; irq_mask = 8'hFF; irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pending", pending, 8'h00);
        check("rst_valid", irq_valid, 1'b0);
        check("rst_onehot", irq_onehot, 8'h00);
        @(negedge clk);
        irq_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            irq_in = vq[i].in; irq_mask = vq[i].mask; irq_ack = vq[i].ack;
            one = 8'h01;
            e.idx = i; e.v = vq[i].v; e.id = vq[i].id; e.pend = vq[i].pend;
            e.oh  = vq[i].v ? (one << vq[i].id) : 8'h00;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_valid", e.idx), irq_valid, e.v);
                if (e.v) check($sformatf("v%0d_id", e.idx), irq_id, e.id);
                check($sformatf("v%0d_onehot", e.idx), irq_onehot, e.oh);
                check($sformatf("v%0d_pending", e.idx), pending, e.pend);
            end
        end

        // async reset in the middle of a presentation
        @(negedge clk); irq_in = 8'h10; irq_ack = 1'b0;
        @(negedge clk); irq_in = 8'h00;
        @(posedge clk); #1;
        check("pre_rst_valid", irq_valid, 1'b1);
        check("pre_rst_id", irq_id, 3'd4);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", irq_valid, 1'b0);
        check("async_onehot", irq_onehot, 8'h00);
        check("async_pending", pending, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", irq_valid, 1'b0);
        @(posedge clk); #1;
        check("post_rst_valid2", irq_valid, 1'b0);
        check("post_rst_pending", pending, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_irq_controller.md
Name: priority_irq_controller

Overview:
- Parametrised, registered successor to the 3-input combinational priority decoder.
- Captures N interrupt request lines into a pending register with per-channel edge/level mode and a runtime mask.
- Selects the highest-index pending unmasked channel and presents it on a valid/ack handshake; also drives a one-hot indicator output (LED/status use).
- Sits between raw request sources (already synchronous to clk) and the service logic/LED outputs.

Parameters:
- N_IRQ, 8, number of request channels (2..32); highest index = highest priority.
- ID_W, $clog2(N_IRQ), width of channel id output.
- EDGE_MODE, all ones (N_IRQ bits), bit i = 1: channel i rising-edge triggered; 0: level triggered.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  N_IRQ  request lines, synchronous to clk.
- irq_mask  input  N_IRQ  1 = channel enabled; 0 = channel masked.
- irq_valid  output  1  a request is being presented.
- irq_id  output  ID_W  index of the presented channel; valid when irq_valid = 1.
- irq_onehot  output  N_IRQ  one-hot of irq_id when irq_valid = 1, else 0.
- irq_ack  input  1  service logic accepts the presented request.
- pending  output  N_IRQ  raw pending register (debug/status).

Behaviour:
- Reset (async assert, sync release):
  - pending, irq_prev, irq_valid, irq_id and irq_onehot all reset to 0.
  - Reset mid-handshake drops the request; nothing is retained.
- Edge detect: irq_prev <= irq_in every cycle. Set condition for channel i:
  - edge mode: irq_in[i] & ~irq_prev[i].
  - level mode: irq_in[i].
- Pending update per channel, per clock:
  - If set condition is true, pending[i] <= 1. Set has priority over clear: an ack of channel i in the same cycle as a new set of i leaves pending[i] = 1.
  - Else if the handshake completes on i (irq_valid & irq_ack & irq_id == i), pending[i] <= 0.
  - Pending bits capture regardless of mask. Masking only blocks selection.
- Two-state FSM, IDLE and PRESENT:
  - IDLE: eligible = pending & irq_mask. If eligible != 0, latch id = highest set index of eligible, set irq_valid = 1 and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: irq_id and irq_onehot stay stable; there is no preemption by a higher channel and no withdrawal if the mask changes. On irq_ack, clear irq_valid and return to IDLE.
  - At least one IDLE cycle occurs between consecutive presentations, so back-to-back handshakes run at most one per 2 cycles.
  - irq_ack is ignored in IDLE.
- Latency: irq_in rising at edge k sets pending at edge k, and irq_valid goes high at edge k+1 (2-cycle input-to-valid latency as seen from the input change).
- Level-mode channel still high after ack: re-sets pending at the ack edge (set wins), so it is re-presented after the IDLE cycle.
- Width rules:
  - irq_id zero-extends into ID_W.
  - irq_onehot = (1 << irq_id) gated by irq_valid.
  - Channels >= N_IRQ do not exist; no wrap-around.

Test Plan:
- Reset: hold rst_n = 0 with irq_in = 8'hFF -> pending = 0, irq_valid = 0, irq_onehot = 0. Release, then pulse bit 2 -> irq_valid = 1, irq_id = 2, irq_onehot = 8'h04 one cycle after pending[2] sets.
- Priority: pulse irq_in = 8'b0000_0111 for one cycle, mask = 8'hFF -> presented order 2, 1, 0, each presentation ack'd. Pending goes 07 -> 03 -> 01 -> 00.
- Masking: pending = 8'h81 with mask = 8'h7F -> id 0 presented, bit 7 stays pending. Set mask = 8'hFF after that ack -> id 7 presented.
- No preemption: id 1 presented, then bit 6 rises before ack -> irq_id stays 1 until ack. Next presentation is 6.
- Set/clear collision: edge channel 3 presented; new rising edge on irq_in[3] in the ack cycle -> pending[3] stays 1 and id 3 is re-presented. Level channel 5 held high -> re-presented after every ack.
- Async reset mid-PRESENT: assert rst_n low between clock edges -> irq_valid drops immediately (no clock edge needed) and pending clears.
